wb_host_master: RTL and testbench
=================================

# wb_host_master

Single-outstanding Wishbone classic initiator for the user area. It accepts read/write commands on a valid/ready command port, runs one Wishbone cycle per command, and returns read data or a timeout error on a valid/ready response port. It is the initiator-side counterpart to the user project's Wishbone slave port. It lets on-chip logic, such as a logic-analyzer-driven sequencer, exercise any user-area slave without the management SoC.

## Interface
Parameters:
- TIMEOUT, 255: maximum bus cycles to wait for ack before aborting; legal range 1..65535.
- TO_W, 16: width of the timeout counter.

Ports:
- wb_clk_i  in  1  clock; all logic is on the rising edge.
- wb_rst_ni  in  1  reset, asynchronous assert, active-low.
- cmd_valid_i  in  1  command present.
- cmd_ready_o  out  1  command accepted when high together with cmd_valid_i.
- cmd_we_i  in  1  1 = write, 0 = read.
- cmd_sel_i  in  4  byte selects.
- cmd_adr_i  in  32  byte address.
- cmd_dat_i  in  32  write data.
- rsp_valid_o  out  1  response present.
- rsp_ready_i  in  1  response consumed when high together with rsp_valid_o.
- rsp_dat_o  out  32  read data; 0 for writes and on error.
- rsp_err_o  out  1  1 = timeout abort.
- wbm_cyc_o, wbm_stb_o, wbm_we_o  out  1 each  Wishbone cycle, strobe and write enable.
- wbm_sel_o  out  4  Wishbone byte selects.
- wbm_adr_o, wbm_dat_o  out  32 each  Wishbone address and write data.
- wbm_ack_i  in  1  slave acknowledge.
- wbm_dat_i  in  32  slave read data.
- err_cnt_o  out  8  saturating count of timeouts.

## Operation
- FSM states: IDLE, BUS, RESP.
- IDLE:
  - cmd_ready_o = 1.
  - On cmd_valid_i, register we, sel, adr and dat into the wbm_* outputs, set cyc and stb, clear the timeout counter, and go to BUS.
- BUS:
  - cyc and stb are held high.
  - wbm_we_o, wbm_sel_o, wbm_adr_o and wbm_dat_o stay stable for the whole cycle.
  - The counter increments every cycle in which ack is low.
  - ack high: clear cyc and stb, capture rsp_dat_o (wbm_dat_i for reads, 0 for writes), set rsp_err_o = 0, go to RESP.
  - Counter reaches TIMEOUT-1 with ack low: clear cyc and stb, set rsp_dat_o = 0 and rsp_err_o = 1, increment err_cnt_o (saturates at 255), go to RESP.
- RESP:
  - rsp_valid_o = 1; rsp_dat_o and rsp_err_o are held.
  - On rsp_ready_i, go to IDLE.
- wbm_ack_i is ignored outside BUS. A stray ack causes no state change and no capture.
- Only one transaction is outstanding at a time. cmd_ready_o is 0 in BUS and RESP.
- Reset asserted in any state:
  - Go to IDLE immediately, dropping cyc and stb asynchronously.
  - The in-flight transaction is lost and no response is produced.

## Timing
- Reset values:
  - All wbm_* outputs are 0.
  - rsp_valid_o = 0, rsp_dat_o = 0, rsp_err_o = 0, err_cnt_o = 0.
  - cmd_ready_o = 1, since reset enters IDLE.
- Cycle 0: command handshake.
- Cycle 1: cyc and stb high.
- Ack sampled high in cycle k (k ≥ 1):
  - cyc and stb are low from cycle k+1.
  - rsp_valid_o is high from cycle k+1.
  - Minimum command-to-response latency is 2 cycles.
- Timeout: cyc and stb are high for exactly TIMEOUT cycles, and rsp_valid_o rises on the following cycle.
- Ack and the timeout threshold in the same cycle: ack wins and the response is a normal, non-error one.
- Response handshake in cycle r: IDLE in cycle r+1, where cmd_ready_o = 1. Next-command turnaround is therefore 1 cycle after the response handshake.
- rsp_ready_i held low: the response stays valid indefinitely and no new command is accepted.

## Test plan
- Write: cmd we=1, sel=F, adr=0x3000_0004, dat=0xDEAD_BEEF; slave acks in cycle 3.
  - Required: wbm_dat_o = 0xDEADBEEF while cyc is high.
  - Required: rsp_valid_o in cycle 4 with rsp_err_o = 0 and rsp_dat_o = 0.
- Read with combinational ack in cycle 1, slave data 0x1234_5678.
  - Required: rsp_valid_o in cycle 2 with rsp_dat_o = 0x12345678.
  - Required: cyc high for exactly 1 cycle.
- Timeout with TIMEOUT=4 and no ack.
  - Required: cyc high for exactly 4 cycles, then rsp_err_o = 1 and rsp_dat_o = 0, err_cnt_o increments to 1.
  - Ack in cycle 4 instead: normal response, err_cnt_o unchanged.
- Backpressure: rsp_ready_i low for 10 cycles while cmd_valid_i is held.
  - Required: rsp_valid_o stable and cmd_ready_o = 0 throughout.
  - Required: the next command is accepted 1 cycle after the response handshake.
- Reset mid-transaction: assert wb_rst_ni low while in BUS.
  - Required: cyc and stb drop without a clock edge, and every output returns to its reset value.
- Robustness: 300 timeouts in a row drive err_cnt_o to 255 and hold it there; a stray ack in IDLE produces no response.

Source files
------------

// File: rtl/wb_host_master.sv
// Single-outstanding Wishbone classic initiator: one bus cycle per command,
// with read data or a timeout error returned on a valid/ready response port.
module wb_host_master #(
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned TO_W    = 16
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_ni,
  input  logic        cmd_valid_i,
  output logic        cmd_ready_o,
  input  logic        cmd_we_i,
  input  logic [3:0]  cmd_sel_i,
  input  logic [31:0] cmd_adr_i,
  input  logic [31:0] cmd_dat_i,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic [31:0] rsp_dat_o,
  output logic        rsp_err_o,
  output logic        wbm_cyc_o,
  output logic        wbm_stb_o,
  output logic        wbm_we_o,
  output logic [3:0]  wbm_sel_o,
  output logic [31:0] wbm_adr_o,
  output logic [31:0] wbm_dat_o,
  input  logic        wbm_ack_i,
  input  logic [31:0] wbm_dat_i,
  output logic [7:0]  err_cnt_o
);

  // state | meaning
  // IDLE  | ready for a command, bus idle
  // BUS   | Wishbone cycle in progress, waiting for ack or timeout
  // RESP  | response held on rsp_* until consumed
  typedef enum logic [1:0] {IDLE, BUS, RESP} state_e;

  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

  state_e           state_q, state_d;
  logic             cyc_q, cyc_d;
  logic             stb_q, stb_d;
  logic             we_q, we_d;
  logic [3:0]       sel_q, sel_d;
  logic [31:0]      adr_q, adr_d;
  logic [31:0]      dat_q, dat_d;
  logic [TO_W-1:0]  cnt_q, cnt_d;
  logic [31:0]      rsp_dat_q, rsp_dat_d;
  logic             rsp_err_q, rsp_err_d;
  logic [7:0]       err_cnt_q, err_cnt_d;

  always_comb begin
    state_d   = state_q;
    cyc_d     = cyc_q;
    stb_d     = stb_q;
    we_d      = we_q;
    sel_d     = sel_q;
    adr_d     = adr_q;
    dat_d     = dat_q;
    cnt_d     = cnt_q;
    rsp_dat_d = rsp_dat_q;
    rsp_err_d = rsp_err_q;
    err_cnt_d = err_cnt_q;
    unique case (state_q)
      IDLE: begin
        if (cmd_valid_i) begin
          we_d    = cmd_we_i;
          sel_d   = cmd_sel_i;
          adr_d   = cmd_adr_i;
          dat_d   = cmd_dat_i;
          cyc_d   = 1'b1;
          stb_d   = 1'b1;
          cnt_d   = '0;
          state_d = BUS;
        end
      end
      BUS: begin
        // ack takes priority over an expiring timeout in the same cycle
        if (wbm_ack_i) begin
          cyc_d     = 1'b0;
          stb_d     = 1'b0;
          rsp_dat_d = we_q ? 32'h0 : wbm_dat_i;
          rsp_err_d = 1'b0;
          state_d   = RESP;
        end else if (cnt_q == TO_LAST) begin
          cyc_d     = 1'b0;
          stb_d     = 1'b0;
          rsp_dat_d = 32'h0;
          rsp_err_d = 1'b1;
          if (err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
          state_d   = RESP;
        end else begin
          cnt_d = cnt_q + TO_W'(1);
        end
      end
      RESP: begin
        if (rsp_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      state_q   <= IDLE;
      cyc_q     <= 1'b0;
      stb_q     <= 1'b0;
      we_q      <= 1'b0;
      sel_q     <= 4'h0;
      adr_q     <= 32'h0;
      dat_q     <= 32'h0;
      cnt_q     <= '0;
      rsp_dat_q <= 32'h0;
      rsp_err_q <= 1'b0;
      err_cnt_q <= 8'h0;
    end else begin
      state_q   <= state_d;
      cyc_q     <= cyc_d;
      stb_q     <= stb_d;
      we_q      <= we_d;
      sel_q     <= sel_d;
      adr_q     <= adr_d;
      dat_q     <= dat_d;
      cnt_q     <= cnt_d;
      rsp_dat_q <= rsp_dat_d;
      rsp_err_q <= rsp_err_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign cmd_ready_o = (state_q == IDLE);
  assign rsp_valid_o = (state_q == RESP);
  assign rsp_dat_o   = rsp_dat_q;
  assign rsp_err_o   = rsp_err_q;
  assign wbm_cyc_o   = cyc_q;
  assign wbm_stb_o   = stb_q;
  assign wbm_we_o    = we_q;
  assign wbm_sel_o   = sel_q;
  assign wbm_adr_o   = adr_q;
  assign wbm_dat_o   = dat_q;
  assign err_cnt_o   = err_cnt_q;

endmodule

// File: tb/tb_wb_host_master.sv
// Directed bench for wb_host_master: expected responses are queued by the
// stimulus and checked by an independent response monitor.
module tb_wb_host_master;

  logic        clk;
  logic        rst_n;
  logic        cmd_valid, cmd_ready, cmd_we;
  logic [3:0]  cmd_sel;
  logic [31:0] cmd_adr, cmd_dat;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [31:0] rsp_dat;
  logic        cyc, stb, we;
  logic [3:0]  sel;
  logic [31:0] adr, wdat;
  logic        ack;
  logic [31:0] ack_dat;
  logic [7:0]  err_cnt;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [31:0] dat;
    logic        err;
  } rsp_t;
  rsp_t exp_q[$];

  wb_host_master #(.TIMEOUT(4), .TO_W(16)) dut (
    .wb_clk_i   (clk),
    .wb_rst_ni  (rst_n),
    .cmd_valid_i(cmd_valid),
    .cmd_ready_o(cmd_ready),
    .cmd_we_i   (cmd_we),
    .cmd_sel_i  (cmd_sel),
    .cmd_adr_i  (cmd_adr),
    .cmd_dat_i  (cmd_dat),
    .rsp_valid_o(rsp_valid),
    .rsp_ready_i(rsp_ready),
    .rsp_dat_o  (rsp_dat),
    .rsp_err_o  (rsp_err),
    .wbm_cyc_o  (cyc),
    .wbm_stb_o  (stb),
    .wbm_we_o   (we),
    .wbm_sel_o  (sel),
    .wbm_adr_o  (adr),
    .wbm_dat_o  (wdat),
    .wbm_ack_i  (ack),
    .wbm_dat_i  (ack_dat),
    .err_cnt_o  (err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are read on the falling edge.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (rst_n && rsp_valid && rsp_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_rsp actual dat=%h err=%b required no response", rsp_dat, rsp_err);
      end else begin
        rsp_t e;
        e = exp_q.pop_front();
        check("rsp_dat", rsp_dat, e.dat);
        check("rsp_err", {31'h0, rsp_err}, {31'h0, e.err});
      end
    end
  end

  task automatic check_reset_values(input string tag);
    check({tag, "_cyc"},       {31'h0, cyc},       32'h0);
    check({tag, "_stb"},       {31'h0, stb},       32'h0);
    check({tag, "_we"},        {31'h0, we},        32'h0);
    check({tag, "_sel"},       {28'h0, sel},       32'h0);
    check({tag, "_adr"},       adr,                32'h0);
    check({tag, "_wdat"},      wdat,               32'h0);
    check({tag, "_rsp_valid"}, {31'h0, rsp_valid}, 32'h0);
    check({tag, "_rsp_dat"},   rsp_dat,            32'h0);
    check({tag, "_rsp_err"},   {31'h0, rsp_err},   32'h0);
    check({tag, "_err_cnt"},   {24'h0, err_cnt},   32'h0);
    check({tag, "_cmd_ready"}, {31'h0, cmd_ready}, 32'h1);
  endtask

  // Issues one command, acks in cycle ack_cyc (0 = never), and measures how many
  // cycles cyc stays high and in which cycle rsp_valid first appears.
  task automatic run_txn(input string name, input logic t_we, input logic [3:0] t_sel,
                         input logic [31:0] t_adr, input logic [31:0] t_dat,
                         input int ack_cyc, input logic [31:0] rdata,
                         input logic [31:0] exp_dat, input logic exp_err,
                         input int exp_ncyc, input int exp_vcyc);
    int   ncyc;
    int   vcyc;
    logic bad;
    rsp_t e;
    ncyc = 0;
    vcyc = 0;
    bad  = 1'b0;
    next_cycle();
    cmd_valid = 1'b1;
    cmd_we    = t_we;
    cmd_sel   = t_sel;
    cmd_adr   = t_adr;
    cmd_dat   = t_dat;
    e.dat = exp_dat;
    e.err = exp_err;
    exp_q.push_back(e);
    @(negedge clk);
    check({name, "_cmd_ready"}, {31'h0, cmd_ready}, 32'h1);
    next_cycle();
    cmd_valid = 1'b0;
    for (int k = 1; k <= 50; k++) begin
      ack     = (k == ack_cyc);
      ack_dat = (k == ack_cyc) ? rdata : 32'hBAD0_BAD0;
      @(negedge clk);
      if (rsp_valid) begin
        vcyc = k;
        break;
      end
      if (cyc) begin
        ncyc++;
        if (stb !== 1'b1 || we !== t_we || sel !== t_sel || adr !== t_adr ||
            wdat !== t_dat || cmd_ready !== 1'b0)
          bad = 1'b1;
      end
      next_cycle();
    end
    ack = 1'b0;
    check({name, "_cyc_len"},   ncyc, exp_ncyc);
    check({name, "_rsp_cycle"}, vcyc, exp_vcyc);
    check({name, "_bus_hold"},  {31'h0, bad}, 32'h0);
  endtask

  initial begin
    rst_n     = 1'b0;
    cmd_valid = 1'b0;
    cmd_we    = 1'b0;
    cmd_sel   = 4'h0;
    cmd_adr   = 32'h0;
    cmd_dat   = 32'h0;
    rsp_ready = 1'b1;
    ack       = 1'b0;
    ack_dat   = 32'h0;
    #12;
    check_reset_values("por");
    next_cycle();
    rst_n = 1'b1;

    run_txn("wr", 1'b1, 4'hF, 32'h3000_0004, 32'hDEAD_BEEF, 3, 32'hFFFF_0000,
            32'h0, 1'b0, 3, 4);
    run_txn("rd", 1'b0, 4'h3, 32'h3000_0010, 32'h0000_0000, 1, 32'h1234_5678,
            32'h1234_5678, 1'b0, 1, 2);
    run_txn("to", 1'b0, 4'hF, 32'h3000_0020, 32'h0000_0000, 0, 32'h0,
            32'h0, 1'b1, 4, 5);
    check("to_err_cnt", {24'h0, err_cnt}, 32'd1);
    run_txn("ack_at_limit", 1'b0, 4'hC, 32'h3000_0024, 32'h0, 4, 32'h5555_AAAA,
            32'h5555_AAAA, 1'b0, 4, 5);
    check("ack_at_limit_err_cnt", {24'h0, err_cnt}, 32'd1);

    // Response backpressure with a second command waiting.
    next_cycle();
    rsp_ready = 1'b0;
    run_txn("bp", 1'b0, 4'hF, 32'h3000_0030, 32'h0, 2, 32'h0BAD_CAFE,
            32'h0BAD_CAFE, 1'b0, 2, 3);
    for (int i = 0; i < 10; i++) begin
      next_cycle();
      if (i == 0) begin
        rsp_t e2;
        cmd_valid = 1'b1;
        cmd_we    = 1'b0;
        cmd_sel   = 4'hF;
        cmd_adr   = 32'h3000_0040;
        cmd_dat   = 32'h0;
        e2.dat = 32'hA5A5_0F0F;
        e2.err = 1'b0;
        exp_q.push_back(e2);
      end
      @(negedge clk);
      check("bp_rsp_valid", {31'h0, rsp_valid}, 32'h1);
      check("bp_rsp_dat",   rsp_dat,            32'h0BAD_CAFE);
      check("bp_cmd_ready", {31'h0, cmd_ready}, 32'h0);
    end
    next_cycle();
    rsp_ready = 1'b1;
    @(negedge clk);
    check("bp_hs_cmd_ready", {31'h0, cmd_ready}, 32'h0);
    next_cycle();
    @(negedge clk);
    check("bp_turn_cmd_ready", {31'h0, cmd_ready}, 32'h1);
    check("bp_turn_rsp_valid", {31'h0, rsp_valid}, 32'h0);
    next_cycle();
    cmd_valid = 1'b0;
    ack       = 1'b1;
    ack_dat   = 32'hA5A5_0F0F;
    @(negedge clk);
    check("bp_next_cyc", {31'h0, cyc}, 32'h1);
    next_cycle();
    ack = 1'b0;
    @(negedge clk);
    check("bp_next_rsp_valid", {31'h0, rsp_valid}, 32'h1);

    // Reset while the bus cycle is open; no response may follow.
    next_cycle();
    cmd_valid = 1'b1;
    cmd_we    = 1'b1;
    cmd_sel   = 4'h5;
    cmd_adr   = 32'h3000_0100;
    cmd_dat   = 32'h1111_2222;
    next_cycle();
    cmd_valid = 1'b0;
    next_cycle();
    #2;
    check("pre_rst_cyc", {31'h0, cyc}, 32'h1);
    rst_n = 1'b0;
    #1;
    check_reset_values("mid_rst");
    next_cycle();
    next_cycle();
    rst_n = 1'b1;

    for (int i = 1; i <= 300; i++) begin
      run_txn("to_sat", 1'b0, 4'hF, 32'h3000_0200, 32'h0, 0, 32'h0,
              32'h0, 1'b1, 4, 5);
      if (i == 1 || i == 255 || i == 300)
        check("sat_err_cnt", {24'h0, err_cnt}, (i < 255) ? i : 255);
    end

    // Stray ack while idle.
    for (int i = 0; i < 3; i++) begin
      next_cycle();
      ack     = 1'b1;
      ack_dat = 32'hFFFF_FFFF;
      @(negedge clk);
      check("stray_rsp_valid", {31'h0, rsp_valid}, 32'h0);
      check("stray_cyc",       {31'h0, cyc},       32'h0);
    end
    next_cycle();
    ack = 1'b0;
    check("stray_err_cnt", {24'h0, err_cnt}, 32'd255);

    repeat (3) next_cycle();
    check("pending_rsps", exp_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
